// File: rtl/seq_booth_multiplier.sv
// rtl/seq_booth_multiplier.sv - iterative radix-2 Booth multiplier, one step per clock
// Operands are extended to WIDTH+1 bits so one datapath serves signed and unsigned modes.
module seq_booth_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [WIDTH+1:0]   acc_q, acc_d;
  logic [WIDTH:0]     mplier_q, mplier_d;
  logic [WIDTH:0]     mcand_q, mcand_d;
  logic               guard_q, guard_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] out_q, out_d;

  logic [WIDTH+1:0]   mcand_ext;
  logic [WIDTH+1:0]   sum;
  logic [WIDTH+1:0]   acc_sh;
  logic [WIDTH:0]     mplier_sh;
  logic               accept;

  assign mcand_ext = {mcand_q[WIDTH], mcand_q};
  assign accept    = start && (state_q == S_IDLE || state_q == S_DONE);

  always_comb begin
    unique case ({mplier_q[0], guard_q})
      2'b01:   sum = acc_q + mcand_ext;
      2'b10:   sum = acc_q - mcand_ext;
      default: sum = acc_q;
    endcase
    // Arithmetic shift of the whole {acc, mplier, guard} chain.
    acc_sh    = {sum[WIDTH+1], sum[WIDTH+1:1]};
    mplier_sh = {sum[0], mplier_q[WIDTH:1]};
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    guard_d  = guard_q;
    cnt_d    = cnt_q;
    out_d    = out_q;

    unique case (state_q)
      S_RUN: begin
        acc_d    = acc_sh;
        mplier_d = mplier_sh;
        guard_d  = mplier_q[0];
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          out_d   = {acc_sh[WIDTH-2:0], mplier_sh};
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      state_d  = S_RUN;
      acc_d    = '0;
      guard_d  = 1'b0;
      cnt_d    = '0;
      mcand_d  = is_signed ? {in1[WIDTH-1], in1} : {1'b0, in1};
      mplier_d = is_signed ? {in2[WIDTH-1], in2} : {1'b0, in2};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      guard_q  <= 1'b0;
      cnt_q    <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      guard_q  <= guard_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
    end
  end

  assign ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE);
  assign out   = out_q;

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// tb/tb_seq_booth_multiplier.sv - directed table-driven bench for seq_booth_multiplier
// Drives a WIDTH=32 and a WIDTH=8 instance sharing clock and reset.
module tb_seq_booth_multiplier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start32 = 1'b0, sgn32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        rdy32, busy32, done32;
  logic [63:0] out32;

  logic        start8 = 1'b0, sgn8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        rdy8, busy8, done8;
  logic [15:0] out8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_booth_multiplier #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .is_signed(sgn32),
    .in1(a32), .in2(b32), .ready(rdy32), .busy(busy32), .done(done32), .out(out32)
  );

  seq_booth_multiplier #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .is_signed(sgn8),
    .in1(a8), .in2(b8), .ready(rdy8), .busy(busy8), .done(done8), .out(out8)
  );

  typedef struct {
    string       name;
    bit          w8;
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Accept one operation, then track latency and busy cycles until done.
  task automatic run_op(input string name, input bit w8, input bit sgn,
                        input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    int n;
    int nb;
    n = 0;
    while (!(w8 ? rdy8 : rdy32) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check({name, "_ready"}, 64'(w8 ? rdy8 : rdy32), 64'd1);
    if (w8) begin
      start8 = 1'b1; sgn8 = sgn; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      start32 = 1'b1; sgn32 = sgn; a32 = a; b32 = b;
    end
    @(posedge clk); #1;
    start8 = 1'b0; start32 = 1'b0;
    a8 = ~a8; b8 = ~b8; sgn8 = ~sgn8;
    a32 = ~a32; b32 = ~b32; sgn32 = ~sgn32;
    n = 1; nb = 0;
    while (!(w8 ? done8 : done32) && n < 200) begin
      if (w8 ? busy8 : busy32) nb++;
      @(posedge clk); #1; n++;
    end
    check({name, "_latency"}, 64'(n), w8 ? 64'd10 : 64'd34);
    check({name, "_busy_cycles"}, 64'(nb), w8 ? 64'd9 : 64'd33);
    check({name, "_out"}, w8 ? {48'b0, out8} : out32, exp);
  endtask

  initial begin : main
    int  n;
    bit  saw_done;

    vecs.push_back('{"u32_ffxff",   1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001});
    vecs.push_back('{"s32_m7x3",    1'b0, 1'b1, 32'hFFFFFFF9, 32'h00000003, 64'hFFFFFFFFFFFFFFEB});
    vecs.push_back('{"u32_m7x3",    1'b0, 1'b0, 32'hFFFFFFF9, 32'h00000003, 64'h00000002FFFFFFEB});
    vecs.push_back('{"s32_minxmin", 1'b0, 1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000});
    vecs.push_back('{"s32_m1xm1",   1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001});
    vecs.push_back('{"s32_minxmax", 1'b0, 1'b1, 32'h80000000, 32'h7FFFFFFF, 64'hC000000080000000});
    vecs.push_back('{"s32_maxxmax", 1'b0, 1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF00000001});
    vecs.push_back('{"u32_2p16sq",  1'b0, 1'b0, 32'h00010000, 32'h00010000, 64'h0000000100000000});
    vecs.push_back('{"s32_zero",    1'b0, 1'b1, 32'h00000000, 32'h80000000, 64'h0000000000000000});
    vecs.push_back('{"u8_ffxff",    1'b1, 1'b0, 32'h000000FF, 32'h000000FF, 64'h000000000000FE01});
    vecs.push_back('{"s8_ffxff",    1'b1, 1'b1, 32'h000000FF, 32'h000000FF, 64'h0000000000000001});
    vecs.push_back('{"s8_80x7f",    1'b1, 1'b1, 32'h00000080, 32'h0000007F, 64'h000000000000C080});
    vecs.push_back('{"u8_80x7f",    1'b1, 1'b0, 32'h00000080, 32'h0000007F, 64'h0000000000003F80});
    vecs.push_back('{"s8_80x80",    1'b1, 1'b1, 32'h00000080, 32'h00000080, 64'h0000000000004000});

    #2;
    check("rst_ready", 64'(rdy32), 64'd1);
    check("rst_busy",  64'(busy32), 64'd0);
    check("rst_done",  64'(done32), 64'd0);
    check("rst_out",   out32, 64'd0);
    check("rst_out8",  {48'b0, out8}, 64'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].w8, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp);

    repeat (3) @(posedge clk);
    #1 check("hold_out8", {48'b0, out8}, 64'h4000);
    check("hold_out32", out32, 64'd0);

    // Back-to-back: request during RUN is ignored, then accepted in DONE.
    start32 = 1'b1; sgn32 = 1'b0; a32 = 32'd5; b32 = 32'd6;
    @(posedge clk); #1;
    a32 = 32'd9; b32 = 32'd9;
    n = 1;
    while (!done32 && n < 200) begin @(posedge clk); #1; n++; end
    check("b2b_first_latency", 64'(n), 64'd34);
    check("b2b_first_out", out32, 64'd30);
    @(posedge clk); #1;
    check("b2b_no_bubble_busy", 64'(busy32), 64'd1);
    check("b2b_no_bubble_ready", 64'(rdy32), 64'd0);
    start32 = 1'b0;
    n = 1;
    while (!done32 && n < 200) begin
      if (n == 20) check("b2b_out_held", out32, 64'd30);
      @(posedge clk); #1; n++;
    end
    check("b2b_second_latency", 64'(n), 64'd34);
    check("b2b_second_out", out32, 64'd81);

    // Reset ten cycles into an operation.
    @(posedge clk); #1;
    start32 = 1'b1; sgn32 = 1'b0; a32 = 32'hFFFFFFFF; b32 = 32'hFFFFFFFF;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out", out32, 64'd0);
    check("midrst_busy", 64'(busy32), 64'd0);
    check("midrst_ready", 64'(rdy32), 64'd1);
    check("midrst_done", 64'(done32), 64'd0);
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done32) saw_done = 1'b1;
    end
    check("midrst_no_done", 64'(saw_done), 64'd0);
    run_op("after_rst_3x4", 1'b0, 1'b0, 32'd3, 32'd4, 64'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_booth_multiplier.md
Name: seq_booth_multiplier

Overview:
Parametrised iterative radix-2 Booth multiplier; one Booth step per clock.
- Supports signed and unsigned operands, selected per operation.
- Uses a start/done handshake and a registered product.
- Intended for the execute stage's multi-cycle multiply path, where a full combinational array multiplier is too large or too slow.

Parameters:
WIDTH, 32, operand width in bits (valid range 4..64); product width is 2*WIDTH.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request a new multiply; sampled only when ready
is_signed  input  1  1 = two's-complement operands, 0 = unsigned; captured with start
in1  input  WIDTH  multiplicand; captured with start
in2  input  WIDTH  multiplier; captured with start
ready  output  1  high in IDLE and DONE; start is accepted only when ready=1
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; out is valid from this cycle onward
out  output  2*WIDTH  product register; holds its value until the next accepted product completes

Behaviour:
- Reset:
  - rst_n low forces state=IDLE immediately (asynchronous).
  - Outputs during reset: ready=1, busy=0, done=0, out=0.
  - All internal registers (accumulator, multiplier shift register, Booth guard bit, step counter) clear to 0.
  - Reset mid-RUN abandons the operation; no done pulse is produced.
- Operand extension:
  - On accept, in1 and in2 are extended to WIDTH+1 bits.
  - is_signed=1: sign-extend. is_signed=0: zero-extend.
  - Running WIDTH+1 Booth steps on the extended operands gives a correct result in both modes.
  - Accumulator is WIDTH+2 bits, which guarantees no overflow when the extended multiplicand is added or subtracted.
- States:
  - IDLE: ready=1. If start=1 at a clock edge, load the operands, counter=0, guard=0, acc=0, and go to RUN.
  - RUN: busy=1, ready=0. Each edge performs one Booth step from {mplier[0], guard}:
    - 01: acc += mcand.
    - 10: acc -= mcand.
    - 00 / 11: no operation.
    - Then arithmetic-shift {acc, mplier, guard} right by 1 and increment the counter.
    - After the step with counter=WIDTH (that is, WIDTH+1 steps total), load out with the low 2*WIDTH bits of {acc, mplier} and go to DONE.
  - DONE: done=1 and ready=1 for exactly one cycle.
    - start=1 at this edge: accept new operands and go to RUN (back-to-back, no IDLE bubble).
    - Otherwise go to IDLE.
- start while busy=1 is ignored. The operands are not captured, and the in-flight operation is unaffected.
- Latency: start accepted at edge k → done high in the cycle after edge k+WIDTH+1. That is WIDTH+2 cycles from accept to result, and the same in both modes.
- Throughput: one product per WIDTH+2 cycles when start is held high.
- Output timing:
  - out changes only on the edge entering DONE, or on reset.
  - in1, in2 and is_signed may change freely after accept.
- Arithmetic is modulo 2^(2*WIDTH).
  - Unsigned: the exact product (it always fits).
  - Signed: the exact two's-complement product, including most-negative × most-negative.

Test Plan:
1. WIDTH=32, unsigned, in1=in2=0xFFFFFFFF → done exactly 34 cycles after accept, out=0xFFFFFFFE00000001; busy high for 33 cycles.
2. WIDTH=32, signed, in1=0xFFFFFFF9 (-7), in2=0x00000003 → out=0xFFFFFFFFFFFFFFEB (-21). Same operands unsigned → out=0x00000002FFFFFFEB.
3. WIDTH=32, signed, in1=in2=0x80000000 → out=0x4000000000000000. Signed -1×-1 → out=0x0000000000000001.
4. start pulsed with in1=5, in2=6, then start held high with in1=9, in2=9 during RUN → the second request is ignored while busy, out=30, then 9×9=81 is accepted in the DONE cycle and completes WIDTH+2 cycles later with no IDLE cycle between.
5. Assert rst_n low 10 cycles into a multiply → out=0, busy=0, ready=1 immediately; no done pulse. A new start after release gives the correct result (3×4=12).
6. WIDTH=8 instance: unsigned 0xFF×0xFF → out=0xFE01; signed 0xFF×0xFF → out=0x0001; signed 0x80×0x7F → out=0xC080; latency 10 cycles.
